// File: rtl/sparse_tree_sum_pipe.sv
// Carry-select sum stage of the pipelined sparse-tree adder: consumes the
// per-4-bit block carries and produces sum, carry_out and signed overflow.
module sparse_tree_sum_pipe #(
    parameter int N_BIT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_BIT-1:0]   operand_1,
    input  logic [N_BIT-1:0]   operand_2,
    input  logic               carry_in,
    input  logic [N_BIT/4-1:0] carries,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_BIT-1:0]   sum,
    output logic               carry_out,
    output logic               overflow
);

    localparam int NB = N_BIT / 4;

    if ((N_BIT % 4 != 0) || (N_BIT < 8)) begin : g_bad_width
        $error("sparse_tree_sum_pipe: N_BIT must be a multiple of 4 and >= 8");
    end

    // Handshake: a beat transfers on any rising edge where valid && ready.
    // Producers hold valid and data until the transfer; ready may depend
    // combinationally on the downstream ready but never on valid.
    logic             s1_valid;
    logic [N_BIT-1:0] s1_a;
    logic [N_BIT-1:0] s1_b;
    logic             s1_cin;
    logic [NB-1:0]    s1_carries;
    logic             s2_valid;
    logic             s1_load;
    logic             s2_adv;

    assign s2_adv   = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;
    assign s1_load  = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_cin     <= 1'b0;
            s1_carries <= '0;
        end else begin
            if (s1_load) begin
                s1_valid   <= 1'b1;
                s1_a       <= operand_1;
                s1_b       <= operand_2;
                s1_cin     <= carry_in;
                s1_carries <= carries;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Each block precomputes both carry-in outcomes and the trusted block
    // carry picks one; carries are never cross-checked against the operands.
    logic [N_BIT-1:0] sum_d;
    logic             overflow_d;

    for (genvar j = 0; j < NB; j++) begin : g_blk
        logic       blk_cin;
        logic [3:0] a_blk;
        logic [3:0] b_blk;
        logic [3:0] sum0;
        logic [3:0] sum1;

        if (j == 0) begin : g_first
            assign blk_cin = s1_cin;
        end else begin : g_rest
            assign blk_cin = s1_carries[j-1];
        end

        assign a_blk = s1_a[4*j +: 4];
        assign b_blk = s1_b[4*j +: 4];
        assign sum0  = a_blk + b_blk;
        assign sum1  = a_blk + b_blk + 4'd1;
        assign sum_d[4*j +: 4] = blk_cin ? sum1 : sum0;
    end

    assign overflow_d = (s1_a[N_BIT-1] == s1_b[N_BIT-1]) &&
                        (sum_d[N_BIT-1] != s1_a[N_BIT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid  <= 1'b1;
                sum       <= sum_d;
                carry_out <= s1_carries[NB-1];
                overflow  <= overflow_d;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sparse_tree_sum_pipe.sv
// Scoreboard bench for sparse_tree_sum_pipe (N_BIT=32): directed beats with
// hand-computed results, checked by an independent output monitor.
module tb_sparse_tree_sum_pipe;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] operand_1 = '0;
    logic [N-1:0] operand_2 = '0;
    logic         carry_in = 1'b0;
    logic [7:0]   carries = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int total = 0;
    int bad = 0;
    logic [33:0] exp_q[$];

    sparse_tree_sum_pipe #(.N_BIT(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand_1(operand_1), .operand_2(operand_2),
        .carry_in(carry_in), .carries(carries),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one beat; its expected result is queued once it is accepted.
    task automatic send_beat(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic cin, input logic [7:0] cy,
                             input logic [N-1:0] e_sum, input logic e_co,
                             input logic e_ov);
        logic acc;
        int   n;
        operand_1 = a;
        operand_2 = b;
        carry_in  = cin;
        carries   = cy;
        in_valid  = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back({e_sum, e_co, e_ov});
        else check("accept_timeout", 64'(acc), 64'd1);
    endtask

    // Monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [33:0] e;
            if (exp_q.size() == 0) begin
                check("unexpected_output", {30'd0, sum, carry_out, overflow}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e[33:2]));
                check("carry_out", 64'(carry_out), 64'(e[1]));
                check("overflow", 64'(overflow), 64'(e[0]));
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_carry_out", 64'(carry_out), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency: valid appears after the second edge following acceptance.
        send_beat(32'h0000000F, 32'h1, 1'b0, 8'h01, 32'h00000010, 1'b0, 1'b0);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(out_valid), 64'd1);

        // Back-to-back beats at full throughput.
        send_beat(32'hFFFFFFFF, 32'h0, 1'b1, 8'hFF, 32'h00000000, 1'b1, 1'b0);
        send_beat(32'h7FFFFFFF, 32'h1, 1'b0, 8'h7F, 32'h80000000, 1'b0, 1'b1);
        send_beat(32'h00000000, 32'h0, 1'b0, 8'h01, 32'h00000010, 1'b0, 1'b0);
        send_beat(32'h12345678, 32'h11111111, 1'b0, 8'h00, 32'h23456789, 1'b0, 1'b0);
        send_beat(32'h80000000, 32'h80000000, 1'b0, 8'h80, 32'h00000000, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Stall: two beats fill the pipe, the third waits for out_ready.
        out_ready = 1'b0;
        fork
            begin
                send_beat(32'h1, 32'h2, 1'b0, 8'h00, 32'h3, 1'b0, 1'b0);
                send_beat(32'h10, 32'h20, 1'b0, 8'h00, 32'h30, 1'b0, 1'b0);
                send_beat(32'h100, 32'h200, 1'b0, 8'h00, 32'h300, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_sum_held", 64'(sum), 64'h3);
                check("stall_q_depth", 64'(exp_q.size()), 64'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;

        // Reset with both stages full.
        out_ready = 1'b0;
        send_beat(32'hAAAA0000, 32'h5555, 1'b0, 8'h00, 32'hAAAA5555, 1'b0, 1'b0);
        send_beat(32'h1111, 32'h2222, 1'b0, 8'h00, 32'h3333, 1'b0, 1'b0);
        @(negedge clk);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(out_valid), 64'd0);
        send_beat(32'h00000FFF, 32'h1, 1'b0, 8'h07, 32'h00001000, 1'b0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
